// File: rtl/data_path_if.sv
// Control-strobe, memory and status bundle between the control unit and the datapath.
// The master drives strobes and read data; the slave (datapath) returns IR, flags
// and the memory address/write-data lines.
interface data_path_if;
  logic       IR_Load;
  logic       MAR_Load;
  logic       PC_Load;
  logic       PC_Inc;
  logic       A_Load;
  logic       B_Load;
  logic       CCR_Load;
  logic [2:0] ALU_Sel;
  logic [1:0] Bus1_Sel;
  logic [1:0] Bus2_Sel;
  logic [7:0] from_memory;
  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic [7:0] address;
  logic [7:0] to_memory;

  modport master (
    output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
    output ALU_Sel, Bus1_Sel, Bus2_Sel, from_memory,
    input  IR, CCR_Result, address, to_memory
  );

  modport slave (
    input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
    input  ALU_Sel, Bus1_Sel, Bus2_Sel, from_memory,
    output IR, CCR_Result, address, to_memory
  );
endinterface

// File: rtl/data_path.sv
// 8-bit datapath: architectural registers IR/MAR/PC/A/B/CCR, two bus muxes and the ALU.
// All sequencing lives in the control unit; this block only reacts to its strobes.
module data_path #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input logic         Clk,
  input logic         Reset,
  data_path_if.slave  dp
);

  logic [7:0] ir_q, ir_d;
  logic [7:0] mar_q, mar_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [3:0] ccr_q, ccr_d;

  logic [7:0] bus1, bus2;
  logic [7:0] alu_y;
  logic [8:0] sum9, dif9;
  logic [7:0] alu_r;
  logic       alu_v, alu_c;
  logic [3:0] alu_flags;

  // Bus1 source mux; also the memory write-data path
  always_comb begin
    bus1 = 8'h00;
    case (dp.Bus1_Sel)
      2'b00:   bus1 = pc_q;
      2'b01:   bus1 = a_q;
      2'b10:   bus1 = b_q;
      default: bus1 = 8'h00;
    endcase
  end

  // ALU: X is Bus1; Y is B except for increment/decrement, which use a constant 1
  always_comb begin
    alu_y = ((dp.ALU_Sel == 3'b001) || (dp.ALU_Sel == 3'b110)) ? 8'h01 : b_q;
    sum9  = {1'b0, bus1} + {1'b0, alu_y};
    // Bit 8 of the 9-bit difference is the unsigned borrow
    dif9  = {1'b0, bus1} - {1'b0, alu_y};
    alu_r = 8'h00;
    alu_v = 1'b0;
    alu_c = 1'b0;
    case (dp.ALU_Sel)
      3'b000, 3'b001: begin
        alu_r = sum9[7:0];
        alu_c = sum9[8];
        alu_v = (bus1[7] == alu_y[7]) && (sum9[7] != bus1[7]);
      end
      3'b010, 3'b110: begin
        alu_r = dif9[7:0];
        alu_c = dif9[8];
        alu_v = (bus1[7] != alu_y[7]) && (dif9[7] != bus1[7]);
      end
      3'b011:  alu_r = bus1 & alu_y;
      3'b100:  alu_r = bus1 | alu_y;
      3'b101:  alu_r = bus1 ^ alu_y;
      default: alu_r = ~bus1;
    endcase
    alu_flags = {alu_r[7], (alu_r == 8'h00), alu_v, alu_c};
  end

  // Bus2 source mux; feeds every register load
  always_comb begin
    bus2 = 8'h00;
    case (dp.Bus2_Sel)
      2'b00:   bus2 = alu_r;
      2'b01:   bus2 = bus1;
      2'b10:   bus2 = dp.from_memory;
      default: bus2 = 8'h00;
    endcase
  end

  // Register next-state: load from Bus2 or hold; PC load wins over increment
  always_comb begin
    ir_d  = dp.IR_Load  ? bus2 : ir_q;
    mar_d = dp.MAR_Load ? bus2 : mar_q;
    a_d   = dp.A_Load   ? bus2 : a_q;
    b_d   = dp.B_Load   ? bus2 : b_q;
    ccr_d = dp.CCR_Load ? alu_flags : ccr_q;
    pc_d  = pc_q;
    if (dp.PC_Load) begin
      pc_d = bus2;
    end else if (dp.PC_Inc) begin
      pc_d = pc_q + 8'd1;
    end
  end

  // Register file with synchronous reset that overrides all loads
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ir_q  <= 8'h00;
      mar_q <= 8'h00;
      pc_q  <= PC_RESET;
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      ccr_q <= 4'h0;
    end else begin
      ir_q  <= ir_d;
      mar_q <= mar_d;
      pc_q  <= pc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      ccr_q <= ccr_d;
    end
  end

  assign dp.IR         = ir_q;
  assign dp.CCR_Result = ccr_q;
  assign dp.address    = mar_q;
  assign dp.to_memory  = bus1;

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed sequences, an ALU vector table,
// and randomized strobes checked against an arithmetic reference model.
module tb_data_path;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int          m_ir, m_mar, m_pc, m_a, m_b;
  logic [3:0]  m_ccr;

  data_path_if dp_if ();

  data_path #(.PC_RESET(8'h10)) dut (
    .Clk   (clk),
    .Reset (rst),
    .dp    (dp_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_r;
    logic [3:0] exp_ccr;
  } alu_vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flags from plain integer arithmetic on unsigned and signed interpretations
  function automatic void ref_alu(input int sel, input int x, input int y,
                                  output int r, output logic [3:0] f);
    int  u, s, sx, sy;
    bit  c, v;
    sx = (x > 127) ? x - 256 : x;
    sy = (y > 127) ? y - 256 : y;
    c  = 0;
    v  = 0;
    u  = 0;
    s  = 0;
    case (sel)
      0: begin u = x + y; s = sx + sy; c = (u > 255); v = (s > 127) || (s < -128); end
      1: begin u = x + 1; s = sx + 1;  c = (u > 255); v = (s > 127) || (s < -128); end
      2: begin u = x - y; s = sx - sy; c = (u < 0);   v = (s > 127) || (s < -128); end
      6: begin u = x - 1; s = sx - 1;  c = (u < 0);   v = (s > 127) || (s < -128); end
      3: u = x & y;
      4: u = x | y;
      5: u = x ^ y;
      default: u = 255 - x;
    endcase
    r = u & 255;
    f = {r > 127, r == 0, v, c};
  endfunction

  function automatic int ref_bus1();
    case (dp_if.Bus1_Sel)
      2'd0:    return m_pc;
      2'd1:    return m_a;
      2'd2:    return m_b;
      default: return 0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    int x, r, b2;
    logic [3:0] f;
    x = ref_bus1();
    ref_alu(int'(dp_if.ALU_Sel), x, m_b, r, f);
    case (dp_if.Bus2_Sel)
      2'd0:    b2 = r;
      2'd1:    b2 = x;
      2'd2:    b2 = int'(dp_if.from_memory);
      default: b2 = 0;
    endcase
    if (rst) begin
      m_ir = 0; m_mar = 0; m_a = 0; m_b = 0; m_ccr = 4'h0; m_pc = 'h10;
    end else begin
      if (dp_if.IR_Load)  m_ir  = b2;
      if (dp_if.MAR_Load) m_mar = b2;
      if (dp_if.A_Load)   m_a   = b2;
      if (dp_if.B_Load)   m_b   = b2;
      if (dp_if.CCR_Load) m_ccr = f;
      if (dp_if.PC_Load)       m_pc = b2;
      else if (dp_if.PC_Inc)   m_pc = (m_pc + 1) % 256;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0;
    dp_if.IR_Load = 0; dp_if.MAR_Load = 0; dp_if.PC_Load = 0; dp_if.PC_Inc = 0;
    dp_if.A_Load = 0; dp_if.B_Load = 0; dp_if.CCR_Load = 0;
    dp_if.ALU_Sel = 3'd0; dp_if.Bus1_Sel = 2'd0; dp_if.Bus2_Sel = 2'd0;
    dp_if.from_memory = 8'h00;
  endtask

  task automatic load_a(input logic [7:0] v);
    idle(); dp_if.Bus2_Sel = 2'd2; dp_if.from_memory = v; dp_if.A_Load = 1; step(); idle();
  endtask

  task automatic load_b(input logic [7:0] v);
    idle(); dp_if.Bus2_Sel = 2'd2; dp_if.from_memory = v; dp_if.B_Load = 1; step(); idle();
  endtask

  task automatic peek(input string name, input logic [1:0] sel, input logic [7:0] exp);
    dp_if.Bus1_Sel = sel;
    #1;
    check(name, dp_if.to_memory, exp);
  endtask

  alu_vec_t vecs [12];

  initial begin
    vecs[0]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 4'b1010};
    vecs[1]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 4'b0101};
    vecs[2]  = '{3'b001, 8'h7F, 8'h00, 8'h80, 4'b1010};
    vecs[3]  = '{3'b010, 8'h00, 8'h01, 8'hFF, 4'b1001};
    vecs[4]  = '{3'b010, 8'h80, 8'h01, 8'h7F, 4'b0010};
    vecs[5]  = '{3'b011, 8'hF0, 8'h3C, 8'h30, 4'b0000};
    vecs[6]  = '{3'b100, 8'hF0, 8'h0F, 8'hFF, 4'b1000};
    vecs[7]  = '{3'b101, 8'hAA, 8'hAA, 8'h00, 4'b0100};
    vecs[8]  = '{3'b110, 8'h00, 8'h55, 8'hFF, 4'b1001};
    vecs[9]  = '{3'b111, 8'h0F, 8'h33, 8'hF0, 4'b1000};
    vecs[10] = '{3'b010, 8'h05, 8'h05, 8'h00, 4'b0100};
    vecs[11] = '{3'b000, 8'h80, 8'h80, 8'h00, 4'b0111};

    idle();
    m_ir = 0; m_mar = 0; m_pc = 0; m_a = 0; m_b = 0; m_ccr = 4'h0;
    @(posedge clk);
    #1;

    // Reset state
    rst = 1'b1; step(); idle();
    check("rst_ir", dp_if.IR, 8'h00);
    check("rst_addr", dp_if.address, 8'h00);
    check("rst_ccr", {4'h0, dp_if.CCR_Result}, 8'h00);
    check("rst_tomem", dp_if.to_memory, 8'h10);
    dp_if.PC_Inc = 1; step(); idle();
    check("pc_inc", dp_if.to_memory, 8'h11);

    // Fetch
    dp_if.Bus2_Sel = 2'd1; dp_if.MAR_Load = 1; step(); idle();
    check("fetch_mar", dp_if.address, 8'h11);
    dp_if.from_memory = 8'h86; dp_if.Bus2_Sel = 2'd2; dp_if.IR_Load = 1; dp_if.PC_Inc = 1;
    step(); idle();
    check("fetch_ir", dp_if.IR, 8'h86);
    check("fetch_pc", dp_if.to_memory, 8'h12);

    // ALU vector table: A <= A op B with flags captured
    foreach (vecs[i]) begin
      load_a(vecs[i].a);
      load_b(vecs[i].b);
      dp_if.Bus1_Sel = 2'd1; dp_if.ALU_Sel = vecs[i].sel; dp_if.Bus2_Sel = 2'd0;
      dp_if.A_Load = 1; dp_if.CCR_Load = 1;
      step(); idle();
      peek($sformatf("alu%0d_r", i), 2'd1, vecs[i].exp_r);
      check($sformatf("alu%0d_ccr", i), {4'h0, dp_if.CCR_Result}, {4'h0, vecs[i].exp_ccr});
    end

    // Decrement of B through Bus1
    load_b(8'h01);
    dp_if.Bus1_Sel = 2'd2; dp_if.ALU_Sel = 3'b110; dp_if.B_Load = 1; dp_if.CCR_Load = 1;
    step(); idle();
    peek("bdec_r", 2'd2, 8'h00);
    check("bdec_ccr", {4'h0, dp_if.CCR_Result}, 8'h04);

    // PC wrap and load-over-increment priority
    dp_if.Bus2_Sel = 2'd2; dp_if.from_memory = 8'hFF; dp_if.PC_Load = 1; step(); idle();
    dp_if.PC_Inc = 1; step(); idle();
    peek("pc_wrap", 2'd0, 8'h00);
    dp_if.PC_Load = 1; dp_if.PC_Inc = 1; dp_if.Bus2_Sel = 2'd2; dp_if.from_memory = 8'h40;
    step(); idle();
    peek("pc_prio", 2'd0, 8'h40);

    // Simultaneous loads all capture the same Bus2 value
    dp_if.Bus2_Sel = 2'd2; dp_if.from_memory = 8'h5A;
    dp_if.IR_Load = 1; dp_if.MAR_Load = 1; dp_if.A_Load = 1; dp_if.B_Load = 1;
    step(); idle();
    check("multi_ir", dp_if.IR, 8'h5A);
    check("multi_mar", dp_if.address, 8'h5A);
    peek("multi_a", 2'd1, 8'h5A);
    peek("multi_b", 2'd2, 8'h5A);

    // Read-before-write on A
    load_a(8'h22);
    dp_if.Bus1_Sel = 2'd1; dp_if.Bus2_Sel = 2'd2; dp_if.from_memory = 8'h33; dp_if.A_Load = 1;
    #1;
    check("rbw_old", dp_if.to_memory, 8'h22);
    step(); idle();
    peek("rbw_new", 2'd1, 8'h33);

    // Reset overrides loads
    rst = 1'b1; dp_if.A_Load = 1; dp_if.PC_Load = 1; dp_if.Bus2_Sel = 2'd2;
    dp_if.from_memory = 8'h99;
    step(); idle();
    peek("rstov_a", 2'd1, 8'h00);
    peek("rstov_pc", 2'd0, 8'h10);
    peek("bus1_zero", 2'd3, 8'h00);

    // Randomized strobes against the reference model
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 19) == 0);
      dp_if.IR_Load  = 1'($urandom); dp_if.MAR_Load = 1'($urandom);
      dp_if.PC_Load  = 1'($urandom); dp_if.PC_Inc   = 1'($urandom);
      dp_if.A_Load   = 1'($urandom); dp_if.B_Load   = 1'($urandom);
      dp_if.CCR_Load = 1'($urandom);
      dp_if.ALU_Sel  = 3'($urandom); dp_if.Bus1_Sel = 2'($urandom);
      dp_if.Bus2_Sel = 2'($urandom); dp_if.from_memory = 8'($urandom);
      #1;
      check("rnd_tomem", dp_if.to_memory, 8'(ref_bus1()));
      step();
      check("rnd_ir", dp_if.IR, 8'(m_ir));
      check("rnd_addr", dp_if.address, 8'(m_mar));
      check("rnd_ccr", {4'h0, dp_if.CCR_Result}, {4'h0, m_ccr});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
